// File: rtl/fetch_pkg.sv
// Shared constants and the fetch buffer entry type for the ELVM instruction fetch stage.
package fetch_pkg;
    localparam int ADDR_W    = 8;
    localparam int INST_W    = 26;
    localparam int BUF_DEPTH = 2;
    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: ROM port, decode handshake, redirect and halt control.
interface inst_fetch_if;
    import fetch_pkg::*;

    logic [ADDR_W-1:0] rom_addr;
    logic [INST_W-1:0] rom_data;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              inst_ready;
    logic              br_taken;
    logic [ADDR_W-1:0] br_target;
    logic              halt;
    logic              halted;

    modport master (
        output rom_addr, inst, inst_pc, inst_valid, halted,
        input  rom_data, inst_ready, br_taken, br_target, halt
    );

    modport slave (
        input  rom_addr, inst, inst_pc, inst_valid, halted,
        output rom_data, inst_ready, br_taken, br_target, halt
    );
endinterface

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched {pc, inst} words; flush wins over push in the same cycle.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);
    fetch_entry_t mem [BUF_DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;

    // When full, wr_ptr equals rd_ptr, so a push alongside a pop refills the slot being vacated.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == 2'd2);
    assign empty = (count == 2'd0);
endmodule

// File: rtl/inst_fetch.sv
// ELVM instruction fetch: PC, redirect/halt control and a 2-entry fetch buffer.
// Optional INST_FETCH_STALL_CNT_EN adds a saturating stall_cnt output.
module inst_fetch
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus
`ifdef INST_FETCH_STALL_CNT_EN
    ,
    output logic [15:0]  stall_cnt
`endif
);
    logic [ADDR_W-1:0] pc;
    logic              pop;
    logic              fetch;
    logic              halted_q;
    fetch_entry_t      head;
    fetch_entry_t      wr_entry;
    logic [1:0]        count;
    logic              full;
    logic              empty;

    assign pop      = !empty && bus.inst_ready;
    assign fetch    = !bus.halt && !bus.br_taken && (!full || pop);
    assign wr_entry = '{pc: pc, inst: bus.rom_data};

    fetch_buf u_buf (
        .clk   (clk),
        .rst   (rst),
        .push  (fetch),
        .pop   (pop),
        .flush (bus.br_taken),
        .din   (wr_entry),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Redirect beats fetch; halt only blocks the increment, never the redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            if (bus.br_taken)  pc <= bus.br_target;
            else if (fetch)    pc <= pc + 1'b1;
            halted_q <= bus.halt && (count == 2'd0);
        end
    end

`ifdef INST_FETCH_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= 16'd0;
        else if (!empty && !bus.inst_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

    assign bus.rom_addr   = pc;
    assign bus.inst       = head.inst;
    assign bus.inst_pc    = head.pc;
    assign bus.inst_valid = !empty;
    assign bus.halted     = halted_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Directed plus randomized bench for inst_fetch against a queue-based reference model.
module tb_inst_fetch;
    typedef struct packed {
        logic [7:0]  pc;
        logic [25:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [25:0] rom [256];
`ifdef INST_FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    inst_fetch_if bus ();

    inst_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef INST_FETCH_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;
    assign bus.rom_data = rom[bus.rom_addr];

    int          tests = 0;
    int          fails = 0;
    ent_t        mq[$];
    logic [7:0]  mpc;
    bit          mhalted;
    int unsigned mstall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("inst_valid", 32'(bus.inst_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("inst", 32'(bus.inst), 32'(mq[0].inst));
            chk("inst_pc", 32'(bus.inst_pc), 32'(mq[0].pc));
        end
        chk("rom_addr", 32'(bus.rom_addr), 32'(mpc));
        chk("halted", 32'(bus.halted), 32'(mhalted));
`ifdef INST_FETCH_STALL_CNT_EN
        chk("stall_cnt", 32'(stall_cnt), mstall);
`endif
    endtask

    // One clock: drive inputs, advance the model across the edge, compare just after it.
    task automatic step(input bit r, input bit rdy, input bit br, input logic [7:0] tgt, input bit h);
        bit p;
        bit f;
        rst            = r;
        bus.inst_ready = rdy;
        bus.br_taken   = br;
        bus.br_target  = tgt;
        bus.halt       = h;
        @(posedge clk);
        if (r) begin
            mq.delete();
            mpc     = 8'h00;
            mhalted = 1'b0;
            mstall  = 0;
        end else begin
            p = (mq.size() > 0) && rdy;
            f = !h && !br && (mq.size() < 2 || p);
            if (mq.size() > 0 && !rdy && mstall < 32'hFFFF) mstall++;
            mhalted = h && (mq.size() == 0);
            if (p) void'(mq.pop_front());
            if (br) begin
                mq.delete();
                mpc = tgt;
            end else if (f) begin
                mq.push_back('{pc: mpc, inst: rom[mpc]});
                mpc = mpc + 8'd1;
            end
        end
        #1;
        check_all();
    endtask

    task automatic do_reset();
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
    endtask

    initial begin
        logic [7:0] exp_pcs [4];
        bit         hl;
        bit         br;
        bit         last_br;
        bit         r;

        for (int i = 0; i < 256; i++) rom[i] = 26'($urandom);
        for (int i = 0; i < 4; i++) rom[i] = 26'h1000001 + 26'(i);
        rst = 1'b1; bus.inst_ready = 1'b0; bus.br_taken = 1'b0;
        bus.br_target = 8'h00; bus.halt = 1'b0;

        // Test 1: reset state and free-running fetch
        do_reset();
        chk("rst_inst", 32'(bus.inst), 32'h0);
        chk("rst_inst_pc", 32'(bus.inst_pc), 32'h0);
        chk("rst_valid", 32'(bus.inst_valid), 32'h0);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 8'h00, 0);
            chk("t1_inst", 32'(bus.inst), 32'h1000001 + i);
            chk("t1_pc", 32'(bus.inst_pc), 32'(i));
        end

        // Test 2: backpressure stalls PC at 2 with ROM[0] held
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 8'h00, 0);
        chk("t2_rom_addr", 32'(bus.rom_addr), 32'h2);
        chk("t2_inst_hold", 32'(bus.inst), 32'(rom[0]));
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 8'h00, 0);
            chk("t2_seq_pc", 32'(bus.inst_pc), 32'(i + 1));
        end

        // Test 3: redirect while full
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 0);
        step(0, 0, 1, 8'h40, 0);
        chk("t3_flush_valid", 32'(bus.inst_valid), 32'h0);
        step(0, 1, 0, 8'h00, 0);
        chk("t3_tgt_inst", 32'(bus.inst), 32'(rom[8'h40]));
        chk("t3_tgt_pc", 32'(bus.inst_pc), 32'h40);

        // Test 4: PC wrap
        exp_pcs[0] = 8'hFE; exp_pcs[1] = 8'hFF; exp_pcs[2] = 8'h00; exp_pcs[3] = 8'h01;
        step(0, 1, 1, 8'hFE, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 8'h00, 0);
            chk("t4_wrap_pc", 32'(bus.inst_pc), 32'(exp_pcs[i]));
        end

        // Test 5: halt drains, halted, resume, reset mid-stream
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 8'h00, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00, 1);
        chk("t5_halted", 32'(bus.halted), 32'h1);
        chk("t5_halt_valid", 32'(bus.inst_valid), 32'h0);
        chk("t5_held_pc", 32'(bus.rom_addr), 32'h2);
        step(0, 1, 0, 8'h00, 0);
        chk("t5_resume_pc", 32'(bus.inst_pc), 32'h2);
        chk("t5_unhalted", 32'(bus.halted), 32'h0);
        step(0, 1, 0, 8'h00, 0);
        step(1, 1, 1, 8'h77, 0);
        chk("t5_rst_addr", 32'(bus.rom_addr), 32'h0);
        chk("t5_rst_valid", 32'(bus.inst_valid), 32'h0);

`ifdef INST_FETCH_STALL_CNT_EN
        // Test 6: stall counter
        do_reset();
        for (int i = 0; i < 11; i++) step(0, 0, 0, 8'h00, 0);
        chk("t6_stall10", 32'(stall_cnt), 32'd10);
        step(1, 0, 0, 8'h00, 0);
        chk("t6_stall_rst", 32'(stall_cnt), 32'd0);
`endif

        // Randomized traffic: backpressure, branch pulses, halt bursts, rare resets
        do_reset();
        hl = 1'b0;
        last_br = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) hl = !hl;
            br = !last_br && ($urandom_range(0, 15) == 0);
            r  = ($urandom_range(0, 99) == 0);
            step(r, $urandom_range(0, 3) != 0, br, 8'($urandom), hl);
            last_br = br;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch stage for the ELVM CPU, directly upstream of the instruction ROM.
- Owns the program counter and drives the ROM address. Captures the 26-bit word returned combinationally in the same cycle.
- Presents captured words, each tagged with its PC, to decode/execute through a valid/ready handshake.
- Handles branch redirects and halt.

Parameters:
ADDR_W, 8, ROM address / PC width.
INST_W, 26, instruction word width.
RESET_PC, 0, PC loaded on reset.
BUF_DEPTH, 2, entries in the fetch buffer; fixed at 2 in this revision.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-high.
rom_addr  out  ADDR_W  ROM read address; equals the PC register.
rom_data  in  INST_W  ROM word at rom_addr, valid in the same cycle (combinational ROM).
inst  out  INST_W  instruction at the buffer head.
inst_pc  out  ADDR_W  PC of inst.
inst_valid  out  1  buffer head holds a valid instruction.
inst_ready  in  1  downstream accepts inst this cycle.
br_taken  in  1  redirect request from execute; single-cycle pulse.
br_target  in  ADDR_W  redirect address, sampled when br_taken=1.
halt  in  1  stop fetching; level-sensitive.
halted  out  1  fetch stopped and buffer empty.

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high.
- Reset values: pc=RESET_PC, buffer empty, inst_valid=0, inst=0, inst_pc=0, halted=0, rom_addr=RESET_PC.
- Handshake:
  - Pop when inst_valid && inst_ready.
  - Fetch when !halt && !br_taken && (count<BUF_DEPTH || pop).
- Fetch: writes {pc, rom_data} into the buffer tail, then pc <= pc+1. Wraps 8'hFF -> 8'h00, no flag.
- Throughput: with inst_ready held high, one instruction per cycle after the first. Latency from a PC load to inst_valid is 1 cycle.
- inst/inst_pc are registered from the buffer head. They are stable while inst_valid && !inst_ready.
- Buffer full (count=2) with no pop: pc and rom_addr hold and no capture occurs.
- Simultaneous pop and fetch while full: allowed; count stays 2.
- Redirect (br_taken=1), at the clock edge:
  - buffer flushed (count=0) and pc <= br_target;
  - any pop in that same cycle still completes;
  - nothing is captured that cycle;
  - inst_valid is 0 in the following cycle, and the first word from br_target appears one cycle after that.
- br_taken has priority over halt and over fetch.
- Halt:
  - while halt=1, no new fetch occurs and pc holds;
  - the buffer keeps draining normally;
  - halted=1 in any cycle where halt=1 && count=0, registered (asserts the cycle after the buffer empties);
  - deasserting halt resumes fetching at the held pc next cycle and clears halted.
- br_taken during halt: pc updates and the buffer flushes; fetching stays stopped until halt drops.
- rst mid-operation: all state returns to reset values on the next edge regardless of other inputs.
- States (derived from count/halt): EMPTY, ONE, FULL, plus a HALTED flag. No separate FSM register is required beyond count and halted.

Optional Feature:
- Macro: INST_FETCH_STALL_CNT_EN.
- When defined:
  - adds output stall_cnt [15:0];
  - counts cycles with inst_valid && !inst_ready;
  - saturates at 16'hFFFF and clears on rst.
- When undefined: the port and counter do not exist and behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - ADDR_W, INST_W, RESET_PC constants;
  - typedef fetch_entry_t = {pc[ADDR_W-1:0], inst[INST_W-1:0]}.
- Sub-module fetch_buf: 2-entry FIFO of fetch_entry_t.
  - Signals: push, pop, flush, head, count, full, empty.
  - Flush has priority over push in the same cycle.
- inst_fetch holds the PC, redirect/halt control and the optional counter.

Test Plan:
1. Reset, ROM[0..3]=26'h1000001..26'h1000004, inst_ready=1 -> inst_valid rises cycle 1; inst/inst_pc sequence (26'h1000001,0),(…02,1),(…03,2),(…04,3) on consecutive cycles.
2. inst_ready=0 for 5 cycles after first valid -> rom_addr stalls at 2, inst holds ROM[0]; on ready=1, ROM[0],ROM[1],ROM[2] follow back-to-back with no gaps or duplicates.
3. br_taken pulse with br_target=8'h40 while buffer full -> next cycle inst_valid=0; following cycle inst=ROM[0x40], inst_pc=8'h40; stale entries never appear.
4. PC at 8'hFE, free run -> inst_pc 8'hFE, 8'hFF, 8'h00, 8'h01.
5. halt=1 with 2 entries buffered, inst_ready=1 -> 2 pops, then halted=1 with inst_valid=0; halt=0 resumes at the held pc; rst mid-stream -> rom_addr=0, inst_valid=0 next cycle.
6. With INST_FETCH_STALL_CNT_EN, inst_ready=0 for 10 valid cycles -> stall_cnt=10; rst -> 0.
